dzcpu_useq: RTL and testbench

DZCPU_USEQ -- requirements
Module: dzcpu_useq

---
 rtl/dzcpu_useq.sv | 141 ++++++++++++++
 tb/tb_dzcpu_useq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: micro-sequencer for the DZCPU core.
// Walks the micro-ROM address (uPC) through each macro-op, fetches opcodes
// through the main or CB-prefix LUT, and raises the PC-increment and flag
// write strobes for the uop currently presented on oUopAddr.
//
// Handshake: iMopValid qualifies iMop/iLutIdx in FETCH and CBFETCH. The state
// waits there until iMopValid is high. iStall freezes EXEC completely: no
// uPC step, no retire, no strobes.
module dzcpu_useq (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [7:0]  iMop,
    input  logic        iMopValid,
    output logic [7:0]  oLutMop,
    output logic        oLutSel,
    input  logic [7:0]  iLutIdx,
    output logic [7:0]  oUopAddr,
    input  logic [2:0]  iFlow,
    input  logic        iFu,
    input  logic        iJcb,
    input  logic        iFlagZ,
    input  logic        iStall,
    output logic        oFetch,
    output logic        oIncPc,
    output logic        oFlagsWe,
    output logic [15:0] oRetired,
    output logic [1:0]  oDbgState
);

    typedef enum logic [1:0] {
        ST_RST     = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXEC    = 2'd2,
        ST_CBFETCH = 2'd3
    } state_t;

    localparam logic [2:0] FLOW_INC        = 3'd1;
    localparam logic [2:0] FLOW_EOF        = 3'd2;
    localparam logic [2:0] FLOW_INC_EOF    = 3'd3;
    localparam logic [2:0] FLOW_INC_EOF_Z  = 3'd4;
    localparam logic [2:0] FLOW_INC_EOF_NZ = 3'd5;

    state_t      state_q, state_d;
    logic [7:0]  upc_q, upc_d;
    logic [15:0] retired_q, retired_d;

    logic        flow_inc_pc;
    logic        flow_eof;
    logic        exec_go;

    // State register, uPC and retire counter; reset wins at any time.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q   <= ST_RST;
            upc_q     <= 8'h00;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            retired_q <= retired_d;
        end
    end

    // Decode the flow code into "bump PC" and "end of macro-op"; 6/7 act as OP.
    always_comb begin
        flow_inc_pc = 1'b0;
        flow_eof    = 1'b0;
        case (iFlow)
            FLOW_INC: begin
                flow_inc_pc = 1'b1;
            end
            FLOW_EOF: begin
                flow_eof = 1'b1;
            end
            FLOW_INC_EOF: begin
                flow_inc_pc = 1'b1;
                flow_eof    = 1'b1;
            end
            FLOW_INC_EOF_Z: begin
                flow_inc_pc = 1'b1;
                flow_eof    = iFlagZ;
            end
            FLOW_INC_EOF_NZ: begin
                flow_inc_pc = 1'b1;
                flow_eof    = ~iFlagZ;
            end
            default: begin
            end
        endcase
    end

    // Next-state, uPC and retire count; a CB prefix jump does not retire.
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        retired_d = retired_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH, ST_CBFETCH: begin
                if (iMopValid) begin
                    upc_d   = iLutIdx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!iStall) begin
                    if (iJcb) begin
                        state_d = ST_CBFETCH;
                        upc_d   = upc_q + 8'd1;
                    end else if (flow_eof) begin
                        state_d   = ST_FETCH;
                        retired_d = retired_q + 16'd1;
                    end else begin
                        // 0xFF wraps to 0x00 by plain 8-bit overflow.
                        upc_d = upc_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Outputs: strobes are combinational so they line up with oUopAddr.
    always_comb begin
        exec_go  = (state_q == ST_EXEC) && !iStall;
        oFetch   = (state_q == ST_FETCH) || (state_q == ST_CBFETCH);
        oLutSel  = (state_q == ST_CBFETCH);
        oIncPc   = exec_go && (iJcb || flow_inc_pc);
        oFlagsWe = exec_go && iFu;
    end

    assign oLutMop   = iMop;
    assign oUopAddr  = upc_q;
    assign oRetired  = retired_q;
    assign oDbgState = state_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: table-driven per-cycle vectors for dzcpu_useq with a
// scoreboard queue, plus hand-written sequences for async reset mid-op and
// retire counter wrap.
module tb_dzcpu_useq;

    localparam int W = 39;

    localparam logic [1:0] S_RST = 2'd0;
    localparam logic [1:0] S_FET = 2'd1;
    localparam logic [1:0] S_EXE = 2'd2;
    localparam logic [1:0] S_CBF = 2'd3;

    localparam logic [2:0] F_OP   = 3'd0;
    localparam logic [2:0] F_INC  = 3'd1;
    localparam logic [2:0] F_EOF  = 3'd2;
    localparam logic [2:0] F_IE   = 3'd3;
    localparam logic [2:0] F_IEZ  = 3'd4;
    localparam logic [2:0] F_IENZ = 3'd5;

    typedef struct packed {
        logic        mv;
        logic [7:0]  mop;
        logic [7:0]  idx;
        logic [2:0]  flow;
        logic        fu;
        logic        jcb;
        logic        z;
        logic        stall;
        logic [1:0]  e_st;
        logic [7:0]  e_addr;
        logic        e_achk;
        logic        e_inc;
        logic        e_fwe;
        logic        e_fetch;
        logic        e_sel;
        logic [15:0] e_ret;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  mop = 8'h00;
    logic        mop_valid = 1'b0;
    logic [7:0]  lut_idx = 8'h00;
    logic [2:0]  flow = 3'd0;
    logic        fu = 1'b0;
    logic        jcb = 1'b0;
    logic        flag_z = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  lut_mop;
    logic        lut_sel;
    logic [7:0]  uop_addr;
    logic        fetch;
    logic        inc_pc;
    logic        flags_we;
    logic [15:0] retired;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dzcpu_useq dut (
        .iClock    (clk),
        .iReset    (rst_n),
        .iMop      (mop),
        .iMopValid (mop_valid),
        .oLutMop   (lut_mop),
        .oLutSel   (lut_sel),
        .iLutIdx   (lut_idx),
        .oUopAddr  (uop_addr),
        .iFlow     (flow),
        .iFu       (fu),
        .iJcb      (jcb),
        .iFlagZ    (flag_z),
        .iStall    (stall),
        .oFetch    (fetch),
        .oIncPc    (inc_pc),
        .oFlagsWe  (flags_we),
        .oRetired  (retired),
        .oDbgState (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t v(input logic mv, input logic [7:0] m, input logic [7:0] idx,
                               input logic [2:0] fl, input logic f, input logic j,
                               input logic zz, input logic st,
                               input logic [1:0] e_st, input logic [7:0] e_addr,
                               input logic e_achk, input logic e_inc, input logic e_fwe,
                               input logic e_fetch, input logic e_sel, input logic [15:0] e_ret);
        vec_t t;
        t.mv = mv; t.mop = m; t.idx = idx; t.flow = fl; t.fu = f; t.jcb = j;
        t.z = zz; t.stall = st; t.e_st = e_st; t.e_addr = e_addr; t.e_achk = e_achk;
        t.e_inc = e_inc; t.e_fwe = e_fwe; t.e_fetch = e_fetch; t.e_sel = e_sel;
        t.e_ret = e_ret;
        return t;
    endfunction

    function automatic logic [W-1:0] pack_exp(input vec_t t);
        return {t.e_achk, t.e_st, t.e_addr, t.e_inc, t.e_fwe, t.e_fetch, t.e_sel,
                t.mop, t.e_ret};
    endfunction

    task automatic check(input string name);
        logic [W-1:0] e;
        logic [W-1:0] a;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got state=%0d addr=%h", name, dbg_state, uop_addr);
            return;
        end
        e = exp_q.pop_front();
        a = {e[38], dbg_state, uop_addr, inc_pc, flags_we, fetch, lut_sel, lut_mop, retired};
        if (!e[38]) begin
            a[35:28] = 8'h00;
            e[35:28] = 8'h00;
        end
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d addr=%h inc=%b fwe=%b fetch=%b sel=%b mop=%h ret=%h | want st=%0d addr=%h inc=%b fwe=%b fetch=%b sel=%b mop=%h ret=%h",
                     name, a[37:36], a[35:28], a[27], a[26], a[25], a[24], a[23:16], a[15:0],
                     e[37:36], e[35:28], e[27], e[26], e[25], e[24], e[23:16], e[15:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t t);
        mop_valid = t.mv;
        mop       = t.mop;
        lut_idx   = t.idx;
        flow      = t.flow;
        fu        = t.fu;
        jcb       = t.jcb;
        flag_z    = t.z;
        stall     = t.stall;
    endtask

    task automatic expect_now(input vec_t t, input string name);
        exp_q.push_back(pack_exp(t));
        check(name);
    endtask

    // Called at a negedge: drive, sample mid-low-phase, return at the next negedge.
    task automatic step(input vec_t t, input string name);
        drive(t);
        exp_q.push_back(pack_exp(t));
        #2;
        check(name);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        // mv mop idx flow fu jcb z stall | st addr achk inc fwe fetch sel ret
        tbl.push_back(v(0,8'h00,8'h00,F_INC,1,0,0,0, S_RST,8'h00,1, 0,0,0,0,16'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0,8'h31,8'h55,F_INC,1,0,0,0, S_FET,8'h00,1, 0,0,1,0,16'd0));
        // LD SP,nn
        tbl.push_back(v(1,8'h31,8'h01,F_OP,0,0,0,0,  S_FET,8'h00,1, 0,0,1,0,16'd0));
        tbl.push_back(v(1,8'h31,8'h99,F_INC,0,0,0,0, S_EXE,8'h01,1, 1,0,0,0,16'd0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,8'h00,8'h00,F_INC,1,0,0,1, S_EXE,8'h02,1, 0,0,0,0,16'd0));
        tbl.push_back(v(0,8'h00,8'h00,F_INC,0,0,0,0, S_EXE,8'h02,1, 1,0,0,0,16'd0));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,1,0,0,0,  S_EXE,8'h03,1, 0,1,0,0,16'd0));
        tbl.push_back(v(0,8'h00,8'h00,F_IE,0,0,0,0,  S_EXE,8'h04,1, 1,0,0,0,16'd0));
        // JR NZ, taken-to-end (Z=1)
        tbl.push_back(v(1,8'h20,8'h11,F_OP,0,0,0,0,  S_FET,8'h04,1, 0,0,1,0,16'd1));
        tbl.push_back(v(0,8'h00,8'h00,F_INC,0,0,0,0, S_EXE,8'h11,1, 1,0,0,0,16'd1));
        tbl.push_back(v(0,8'h00,8'h00,F_INC,0,0,0,0, S_EXE,8'h12,1, 1,0,0,0,16'd1));
        tbl.push_back(v(0,8'h00,8'h00,F_IEZ,0,0,1,0, S_EXE,8'h13,1, 1,0,0,0,16'd1));
        // JR NZ, continues (Z=0)
        tbl.push_back(v(1,8'h20,8'h11,F_OP,0,0,0,0,  S_FET,8'h13,1, 0,0,1,0,16'd2));
        tbl.push_back(v(0,8'h00,8'h00,F_INC,0,0,0,0, S_EXE,8'h11,1, 1,0,0,0,16'd2));
        tbl.push_back(v(0,8'h00,8'h00,F_INC,0,0,0,0, S_EXE,8'h12,1, 1,0,0,0,16'd2));
        tbl.push_back(v(0,8'h00,8'h00,F_IEZ,0,0,0,0, S_EXE,8'h13,1, 1,0,0,0,16'd2));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_EXE,8'h14,1, 0,0,0,0,16'd2));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_EXE,8'h15,1, 0,0,0,0,16'd2));
        tbl.push_back(v(0,8'h00,8'h00,F_EOF,0,0,0,0, S_EXE,8'h16,1, 0,0,0,0,16'd2));
        // flows 7/6 as OP, INC_EOF_NZ both ways
        tbl.push_back(v(1,8'h00,8'h40,F_OP,0,0,0,0,  S_FET,8'h16,1, 0,0,1,0,16'd3));
        tbl.push_back(v(0,8'h00,8'h00,3'd7,0,0,0,0,  S_EXE,8'h40,1, 0,0,0,0,16'd3));
        tbl.push_back(v(0,8'h00,8'h00,3'd6,0,0,0,0,  S_EXE,8'h41,1, 0,0,0,0,16'd3));
        tbl.push_back(v(0,8'h00,8'h00,F_IENZ,0,0,1,0,S_EXE,8'h42,1, 1,0,0,0,16'd3));
        tbl.push_back(v(0,8'h00,8'h00,F_IENZ,0,0,0,0,S_EXE,8'h43,1, 1,0,0,0,16'd3));
        // CB BIT 7,H
        tbl.push_back(v(1,8'hCB,8'h0D,F_OP,0,0,0,0,  S_FET,8'h43,1, 0,0,1,0,16'd4));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_EXE,8'h0D,1, 0,0,0,0,16'd4));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_EXE,8'h0E,1, 0,0,0,0,16'd4));
        tbl.push_back(v(0,8'h00,8'h00,F_EOF,1,1,0,1, S_EXE,8'h0F,1, 0,0,0,0,16'd4));
        tbl.push_back(v(0,8'h00,8'h00,F_EOF,0,1,0,0, S_EXE,8'h0F,1, 1,0,0,0,16'd4));
        tbl.push_back(v(0,8'h7C,8'h00,F_OP,1,0,0,0,  S_CBF,8'h00,0, 0,0,1,1,16'd4));
        tbl.push_back(v(1,8'h7C,8'h10,F_OP,0,0,0,0,  S_CBF,8'h00,0, 0,0,1,1,16'd4));
        tbl.push_back(v(0,8'h00,8'h00,F_EOF,1,0,0,0, S_EXE,8'h10,1, 0,1,0,0,16'd4));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_FET,8'h10,1, 0,0,1,0,16'd5));
        // uPC wrap 0xFF -> 0x00
        tbl.push_back(v(1,8'h00,8'hFE,F_OP,0,0,0,0,  S_FET,8'h10,1, 0,0,1,0,16'd5));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_EXE,8'hFE,1, 0,0,0,0,16'd5));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_EXE,8'hFF,1, 0,0,0,0,16'd5));
        tbl.push_back(v(0,8'h00,8'h00,F_EOF,0,0,0,0, S_EXE,8'h00,1, 0,0,0,0,16'd5));
        tbl.push_back(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_FET,8'h00,1, 0,0,1,0,16'd6));

        // Reset state while iReset held low
        repeat (2) @(negedge clk);
        expect_now(v(0,8'h00,8'h00,F_OP,0,0,0,0, S_RST,8'h00,1, 0,0,0,0,16'd0), "reset_hold");

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Async reset in the middle of a JR at uop 0x15 (21)
        step(v(1,8'h20,8'h11,F_OP,0,0,0,0,  S_FET,8'h00,1, 0,0,1,0,16'd6), "jr2_fetch");
        step(v(0,8'h00,8'h00,F_INC,0,0,0,0, S_EXE,8'h11,1, 1,0,0,0,16'd6), "jr2_u17");
        step(v(0,8'h00,8'h00,F_INC,0,0,0,0, S_EXE,8'h12,1, 1,0,0,0,16'd6), "jr2_u18");
        step(v(0,8'h00,8'h00,F_IEZ,0,0,0,0, S_EXE,8'h13,1, 1,0,0,0,16'd6), "jr2_u19");
        step(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_EXE,8'h14,1, 0,0,0,0,16'd6), "jr2_u20");
        drive(v(1,8'h00,8'h00,F_INC,1,0,0,0, S_EXE,8'h15,1, 1,1,0,0,16'd6));
        #2;
        expect_now(v(1,8'h00,8'h00,F_INC,1,0,0,0, S_EXE,8'h15,1, 1,1,0,0,16'd6), "jr2_u21");
        #1 rst_n = 1'b0;
        #1;
        expect_now(v(1,8'h00,8'h00,F_INC,1,0,0,0, S_RST,8'h00,1, 0,0,0,0,16'd0), "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(v(1,8'h00,8'h05,F_INC,1,0,0,0, S_RST,8'h00,1, 0,0,0,0,16'd0), "rel_cycle1");
        step(v(0,8'h00,8'h05,F_OP,0,0,0,0,  S_FET,8'h00,1, 0,0,1,0,16'd0), "rel_cycle2");

        // Retire counter wrap: preset 0xFFFF then complete one op
        force dut.retired_q = 16'hFFFF;
        #1 release dut.retired_q;
        step(v(1,8'h00,8'h05,F_OP,0,0,0,0,  S_FET,8'h00,1, 0,0,1,0,16'hFFFF), "wrap_fetch");
        step(v(0,8'h00,8'h00,F_EOF,0,0,0,0, S_EXE,8'h05,1, 0,0,0,0,16'hFFFF), "wrap_exec");
        step(v(0,8'h00,8'h00,F_OP,0,0,0,0,  S_FET,8'h05,1, 0,0,1,0,16'h0000), "wrap_done");

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
